// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one external combinational ALU. At most one
// operation is in flight. Each operation goes IDLE -> EXEC -> RESP:
//   IDLE : round-robin pick between the valid requesters, then latch a/b/op
//   EXEC : drive the latched operands to the ALU for exactly one cycle and
//          capture result/zero into the granted port's response registers
//   RESP : hold the response until the granted requester takes it
// When both requesters are valid, the one that was not served last wins.
// After reset, requester 0 wins the first tie.
//
// Ports
//   clk, rst_n                clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/op   requester 0 operation handshake
//   rsp0_valid/ready          requester 0 response handshake
//   rsp0_result/zero          requester 0 registered ALU result and Zero
//   req1_*, rsp1_*            the same for requester 1
//   alu_srca/srcb/op          to the ALU; all zero (ADD 0,0) outside EXEC
//   alu_result/zero           from the ALU, sampled at the end of EXEC
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  // Requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,

  // Requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,

  // Shared ALU
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;  // port served most recently
  logic             grant_q, grant_d;            // port owning the current op
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp1_zero_q, rsp1_zero_d;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic any_req;
  logic both_req;
  logic win_id;      // 0: requester 0 wins, 1: requester 1 wins
  logic accept;      // a request handshake completes this cycle
  logic rsp_ready_sel;

  always_comb begin
    any_req  = req0_valid | req1_valid;
    both_req = req0_valid & req1_valid;
    // On a tie the port not served last wins; otherwise the lone valid port.
    win_id   = both_req ? ~last_grant_q : req1_valid;
    // rst_n gates ready so no handshake can land while reset is held.
    accept   = (state_q == StIdle) & any_req & rst_n;
  end

  assign req0_ready = accept & ~win_id;
  assign req1_ready = accept &  win_id;

  assign rsp_ready_sel = grant_q ? rsp1_ready : rsp0_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;

    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          grant_d = win_id;
          a_d     = win_id ? req1_a  : req0_a;
          b_d     = win_id ? req1_b  : req0_b;
          op_d    = win_id ? req1_op : req0_op;
          state_d = StExec;
        end
      end

      StExec: begin
        // Only the granted port's response registers are written.
        if (grant_q) begin
          rsp1_valid_d  = 1'b1;
          rsp1_result_d = alu_result;
          rsp1_zero_d   = alu_zero;
        end else begin
          rsp0_valid_d  = 1'b1;
          rsp0_result_d = alu_result;
          rsp0_zero_d   = alu_zero;
        end
        state_d = StResp;
      end

      StResp: begin
        if (rsp_ready_sel) begin
          if (grant_q) begin
            rsp1_valid_d = 1'b0;
          end else begin
            rsp0_valid_d = 1'b0;
          end
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end

      default: begin
        // Unreachable encoding: drop any response and return to idle.
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;  // makes requester 0 win the first tie
      grant_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic in_exec;
  assign in_exec = (state_q == StExec);

  // ALU sees the latched operation only during EXEC, otherwise ADD 0,0.
  assign alu_srca = in_exec ? a_q  : '0;
  assign alu_srcb = in_exec ? b_q  : '0;
  assign alu_op   = in_exec ? op_q : 4'd0;

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Drives both requesters, models the external ALU, and checks the arbiter
// with a scoreboard. A monitor on the falling edge tracks the transaction in
// flight at the level of "who was granted, how many cycles ago". It checks
// ready/valid timing, ALU drive, and response contents against per-port
// expected queues that are filled when a request handshake is seen.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [3:0]   req0_op, req1_op, alu_op;
  logic [W-1:0] alu_srca, alu_srcb, alu_result;
  logic         alu_zero;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_zero  (rsp0_zero),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_zero  (rsp1_zero),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // External ALU: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
  // 10 BEQ 11 BNE 12 BLT 13 BGE 14 BGEU, 15 undefined -> 0.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return W'(($signed(a) < $signed(b)) ? 1 : 0);
      4'd9:    return W'((a < b) ? 1 : 0);
      4'd10:   return W'((a == b) ? 1 : 0);
      4'd11:   return W'((a != b) ? 1 : 0);
      4'd12:   return W'(($signed(a) < $signed(b)) ? 1 : 0);
      4'd13:   return W'(($signed(a) >= $signed(b)) ? 1 : 0);
      4'd14:   return W'((a >= b) ? 1 : 0);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_srca, alu_srcb, alu_op);
  assign alu_zero   = (alu_result == '0);

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  int           grant_log[$];
  logic [W-1:0] act0_log[$];
  logic [W-1:0] act1_log[$];

  bit           busy = 1'b0;   // one operation in flight
  int           bport = 0;     // its requester
  int           age = 0;       // falling edges since its request handshake
  bit           last = 1'b1;   // requester served most recently
  logic [W-1:0] la, lb;
  logic [3:0]   lop;
  logic [W-1:0] hold_res[2];
  logic         hold_z[2];
  bit           ev0, ev1, er0, er1;
  exp_t         f;

  task automatic push_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op);
    exp_t e;
    e.res = alu_fn(a, b, op);
    e.z   = (e.res == '0);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
    grant_log.push_back(p);
    busy  = 1'b1;
    bport = p;
    age   = 0;
    la    = a;
    lb    = b;
    lop   = op;
  endtask

  task automatic rsp_content(input int p, input logic v, input logic [W-1:0] res,
                             input logic z);
    int sz;
    sz = (p == 0) ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) begin
        check($sformatf("rsp%0d_unexpected", p), v, 1'b0);
      end else begin
        f = (p == 0) ? q0[0] : q1[0];
        check($sformatf("rsp%0d_result", p), res, f.res);
        check($sformatf("rsp%0d_zero", p), z, f.z);
      end
    end else begin
      check($sformatf("rsp%0d_result_hold", p), res, hold_res[p]);
      check($sformatf("rsp%0d_zero_hold", p), z, hold_z[p]);
    end
  endtask

  initial begin
    hold_res[0] = '0; hold_res[1] = '0;
    hold_z[0]   = 1'b0; hold_z[1] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp0_valid", rsp0_valid, 1'b0);
      check("rst_rsp1_valid", rsp1_valid, 1'b0);
      check("rst_rsp0_result", rsp0_result, '0);
      check("rst_rsp1_result", rsp1_result, '0);
      check("rst_rsp0_zero", rsp0_zero, 1'b0);
      check("rst_rsp1_zero", rsp1_zero, 1'b0);
      check("rst_req0_ready", req0_ready, 1'b0);
      check("rst_req1_ready", req1_ready, 1'b0);
      check("rst_alu_op", alu_op, 4'd0);
      check("rst_alu_srca", alu_srca, '0);
      q0.delete();
      q1.delete();
      busy = 1'b0;
      age  = 0;
      last = 1'b1;
      hold_res[0] = '0; hold_res[1] = '0;
      hold_z[0]   = 1'b0; hold_z[1] = 1'b0;
    end else begin
      if (busy) age++;

      // ALU carries the operation exactly one cycle after its handshake.
      if (busy && age == 1) begin
        check("alu_srca_exec", alu_srca, la);
        check("alu_srcb_exec", alu_srcb, lb);
        check("alu_op_exec", alu_op, lop);
      end else begin
        check("alu_srca_idle", alu_srca, '0);
        check("alu_srcb_idle", alu_srcb, '0);
        check("alu_op_idle", alu_op, 4'd0);
      end

      ev0 = busy && bport == 0 && age >= 2;
      ev1 = busy && bport == 1 && age >= 2;
      check("rsp0_valid", rsp0_valid, ev0);
      check("rsp1_valid", rsp1_valid, ev1);
      rsp_content(0, rsp0_valid, rsp0_result, rsp0_zero);
      rsp_content(1, rsp1_valid, rsp1_result, rsp1_zero);

      er0 = !busy && req0_valid && (!req1_valid || last);
      er1 = !busy && req1_valid && (!req0_valid || !last);
      check("req0_ready", req0_ready, er0);
      check("req1_ready", req1_ready, er1);

      if (ev0 && rsp0_valid && rsp0_ready && q0.size() > 0) begin
        f = q0.pop_front();
        hold_res[0] = f.res;
        hold_z[0]   = f.z;
        act0_log.push_back(rsp0_result);
        busy = 1'b0;
        last = 1'b0;
      end
      if (ev1 && rsp1_valid && rsp1_ready && q1.size() > 0) begin
        f = q1.pop_front();
        hold_res[1] = f.res;
        hold_z[1]   = f.z;
        act1_log.push_back(rsp1_result);
        busy = 1'b0;
        last = 1'b1;
      end

      if (!busy && req0_valid && req0_ready)      push_req(0, req0_a, req0_b, req0_op);
      else if (!busy && req1_valid && req1_ready) push_req(1, req1_a, req1_b, req1_op);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    int n = 0;
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 300);
    if (!req0_ready) check("drive0_handshake_timeout", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
  endtask

  task automatic drive1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    int n = 0;
    req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req1_ready && n < 300);
    if (!req1_ready) check("drive1_handshake_timeout", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_op(output logic [W-1:0] a, output logic [W-1:0] b,
                         output logic [3:0] op);
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
    op = 4'($urandom_range(0, 15));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [W-1:0] held;
  bit           d0, d1;

  initial begin
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD 5+7 on port 0; response visible two cycles after the handshake.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive0(32'd5, 32'd7, 4'd0);
    @(negedge clk);
    check("t1_valid_early", rsp0_valid, 1'b0);
    @(negedge clk);
    check("t1_valid", rsp0_valid, 1'b1);
    check("t1_result", rsp0_result, 32'd12);
    check("t1_zero", rsp0_zero, 1'b0);
    check("t1_rsp1_quiet", rsp1_valid, 1'b0);
    wait_idle();

    // SUB 0x10-0x10 on port 1 -> zero.
    drive1(32'h10, 32'h10, 4'd1);
    @(negedge clk);
    @(negedge clk);
    check("t2_result", rsp1_result, 32'd0);
    check("t2_zero", rsp1_zero, 1'b1);
    wait_idle();

    // Tie straight after reset: port 0 first.
    reset_pulse();
    grant_log.delete();
    fork
      drive0(32'hF0, 32'h0F, 4'd3);
      drive1(32'hFFFF_FFFF, 32'd1, 4'd8);
    join
    wait_idle();
    check("t3_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t3_first", grant_log[0], 0);
      check("t3_second", grant_log[1], 1);
    end
    if (act0_log.size() > 0) check("t3_res0", act0_log[$], 32'hFF);
    if (act1_log.size() > 0) check("t3_res1", act1_log[$], 32'd1);

    // Both continuously valid: strict alternation.
    grant_log.delete();
    fork
      begin
        drive0(32'd100, 32'd1, 4'd0);
        drive0(32'd200, 32'd2, 4'd1);
        drive0(32'hFF00, 32'h0FF0, 4'd2);
      end
      begin
        drive1(32'd3, 32'd4, 4'd5);
        drive1(32'd9, 32'd9, 4'd10);
        drive1(32'h8000_0000, 32'd4, 4'd7);
      end
    join
    wait_idle();
    check("t4_grants", grant_log.size(), 6);
    if (grant_log.size() == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("t4_grant%0d", i), grant_log[i], i % 2);
    end

    // Response back-pressure on port 0 while port 1 waits.
    rsp0_ready = 1'b0;
    drive0(32'd21, 32'd21, 4'd4);
    @(negedge clk);
    @(negedge clk);
    check("t5_valid", rsp0_valid, 1'b1);
    held = rsp0_result;
    @(posedge clk); #1;
    req1_a = 32'd7; req1_b = 32'd8; req1_op = 4'd9; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stable", rsp0_result, held);
      check("t5_req1_blocked", req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("t5_req1_in_resp", req1_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_req1_accept", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset during EXEC discards the operation.
    drive0(32'd1, 32'd1, 4'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rsp0_valid", rsp0_valid, 1'b0);
    check("t6_rsp0_result", rsp0_result, '0);
    check("t6_rsp1_result", rsp1_result, '0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_log.delete();
    fork
      drive0(32'd2, 32'd3, 4'd0);
      drive1(32'd4, 32'd5, 4'd0);
    join
    wait_idle();
    if (grant_log.size() > 0) check("t6_tie_after_reset", grant_log[0], 0);
    else                      check("t6_no_grant", grant_log.size(), 1);

    // Randomized traffic with random response back-pressure.
    d0 = 1'b0; d1 = 1'b0;
    fork
      begin
        logic [W-1:0] a, b;
        logic [3:0]   op;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rand_op(a, b, op);
          drive0(a, b, op);
        end
        d0 = 1'b1;
      end
      begin
        logic [W-1:0] a, b;
        logic [3:0]   op;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          rand_op(a, b, op);
          drive1(a, b, op);
        end
        d1 = 1'b1;
      end
      begin
        while (!(d0 && d1)) begin
          @(posedge clk); #1;
          rsp0_ready = 1'($urandom_range(0, 1));
          rsp1_ready = 1'($urandom_range(0, 1));
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
      end
    join
    wait_idle();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (tests=%0d)", tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (4-bit ALUOp, WIDTH-bit operands, Result and Zero outputs) between two requesters.
  - Port 0: main datapath sequencer.
  - Port 1: auxiliary address/branch-compare unit.
- Round-robin arbitration, valid/ready handshakes on request and response sides, registered results.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged and external.

Parameters:
- WIDTH, 32, operand/result width passed to and from the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 SrcA.
- req0_b  in  WIDTH  requester 0 SrcB.
- req0_op  in  4  requester 0 ALUOp (ADD=0 … BGEU=14).
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_result  out  WIDTH  registered ALU result.
- rsp0_zero  out  1  registered ALU Zero.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as port 0, for requester 1.
- alu_srca  out  WIDTH  to ALU SrcA.
- alu_srcb  out  WIDTH  to ALU SrcB.
- alu_op  out  4  to ALU ALUOp.
- alu_result  in  WIDTH  from ALU ALUResult.
- alu_zero  in  1  from ALU Zero.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - All rspN_valid=0, rspN_result=0, rspN_zero=0.
  - Operand registers 0, op register 0.
  - No handshake can complete while rst_n=0.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - If exactly one reqN_valid=1, that requester wins.
  - If both are valid, the requester not equal to last_grant wins.
  - reqN_ready=1 combinationally for the winner only; the loser's ready stays 0.
  - On handshake: latch a, b, op and grant id; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly one cycle):
  - alu_srca/alu_srcb/alu_op driven from the latched registers.
  - At the clock edge, alu_result/alu_zero are captured into the granted port's rsp registers.
  - rspN_valid rises; go to RESP.
- RESP:
  - rspN_valid held at 1 with result/zero stable until rspN_ready=1.
  - On handshake: rspN_valid=0, last_grant=grant, go to IDLE.
  - No request is accepted in RESP.
- ALU drive outside EXEC: alu_srca=0, alu_srcb=0, alu_op=0 (ADD).
- Latency and throughput:
  - req handshake in cycle T gives rsp valid visible from cycle T+2.
  - Minimum 3 cycles per operation.
  - Only one operation is in flight at a time.
- Requester rules:
  - Once valid is asserted, a, b, op and valid stay stable until ready; withdrawal is illegal.
  - rspN_ready may be held high permanently.
- Fairness:
  - With both requesters continuously valid, grants strictly alternate 0,1,0,1.
  - Neither requester waits more than one other operation.
- Op codes 15 (undefined): passed through unchanged. The ALU returns 0, so result=0 and zero=1; no error is flagged.
- Only the granted port's rsp registers change. The other port's rsp registers keep their last values with valid=0.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, everything returns to reset values, and no response is produced.
- Result width: WIDTH bits unchanged; no sign handling in the arbiter.

Test Plan:
- Reset, req0 ADD a=5 b=7 -> req0_ready in first IDLE cycle; rsp0_valid 2 cycles later; result=12, zero=0; rsp1_valid stays 0.
- req1 SUB a=0x10 b=0x10, rsp1_ready=1 -> rsp1_result=0, rsp1_zero=1; state back to IDLE the cycle after handshake.
- Both valid right after reset (req0 OR 0xF0|0x0F, req1 SLT a=-1 b=1) -> req0 served first (0xFF), then req1 (1); req1_ready never high while req0 is in flight.
- Both valid continuously for 6 operations -> grant order 0,1,0,1,0,1; each rsp carries that requester's operands.
- rsp0_ready held low 5 cycles after rsp0_valid -> result stable, req1_valid=1 not accepted until the cycle after rsp0 handshake.
- Assert rst_n=0 during EXEC of req0 ADD 1+1 -> all rsp valid=0 immediately and result=0; after release, a tie goes to requester 0.
